instr_exec: RTL and testbench

INSTR_EXEC -- requirements
Module: instr_exec

---
 rtl/instr_exec.sv | 138 +++++++++++++
 tb/tb_instr_exec.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_exec.sv
// Multi-cycle instruction executor: accepts one instruction at a time, reads operands,
// and produces either a register write-back, a branch pulse, or nothing.
module instr_exec #(
  parameter int unsigned M = 32,
  parameter int unsigned N = 8,
  localparam int unsigned AddrSz = $clog2(M),
  localparam int unsigned IW = 4 + 2 * AddrSz + N
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  input  logic [IW-1:0]     instr,
  output logic              instr_ready,
  output logic [AddrSz-1:0] Rd,
  output logic [AddrSz-1:0] Rs,
  input  logic [N-1:0]      Rd_data,
  input  logic [N-1:0]      Rs_data,
  output logic [N-1:0]      Wdata,
  output logic              w_enable,
  output logic              branch_taken,
  output logic [N-1:0]      branch_offset
);

  localparam int unsigned CntW = $clog2(N + 1);
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_ADDI = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_MULI = 4'd4;
  localparam logic [3:0] OP_BEQ  = 4'd5;

  typedef enum logic [1:0] {IDLE, EXEC, MUL, WB} state_t;

  state_t          state;
  logic [IW-1:0]   instr_q;
  logic [N-1:0]    mplier;
  logic [2*N-1:0]  mcand;
  logic [2*N-1:0]  acc;
  logic [CntW-1:0] cnt;

  logic [3:0]      op;
  logic [N-1:0]    imm;
  logic [2*N-1:0]  acc_next;

  assign op       = instr_q[IW-1 -: 4];
  assign imm      = instr_q[N-1:0];
  // One shift-add step: add the shifted multiplicand when the current multiplier bit is set
  assign acc_next = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      instr_q       <= '0;
      mplier        <= '0;
      mcand         <= '0;
      acc           <= '0;
      cnt           <= '0;
      instr_ready   <= 1'b1;
      Rd            <= '0;
      Rs            <= '0;
      Wdata         <= '0;
      w_enable      <= 1'b0;
      branch_taken  <= 1'b0;
      branch_offset <= '0;
    end else begin
      w_enable     <= 1'b0;
      branch_taken <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid) begin
            instr_q     <= instr;
            Rd          <= instr[N+AddrSz +: AddrSz];
            Rs          <= instr[N +: AddrSz];
            instr_ready <= 1'b0;
            state       <= EXEC;
          end
        end
        EXEC: begin
          case (op)
            OP_ADD: begin
              Wdata    <= Rd_data + Rs_data;
              w_enable <= 1'b1;
              state    <= WB;
            end
            OP_ADDI: begin
              Wdata    <= Rs_data + imm;
              w_enable <= 1'b1;
              state    <= WB;
            end
            OP_SUB: begin
              Wdata    <= Rd_data - Rs_data;
              w_enable <= 1'b1;
              state    <= WB;
            end
            OP_MULI: begin
              mcand  <= {N'(0), Rs_data};
              mplier <= imm;
              acc    <= '0;
              cnt    <= '0;
              state  <= MUL;
            end
            OP_BEQ: begin
              if (Rd_data == Rs_data) begin
                branch_taken  <= 1'b1;
                branch_offset <= imm;
              end
              state <= WB;
            end
            default: begin
              instr_ready <= 1'b1;
              state       <= IDLE;
            end
          endcase
        end
        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CntW'(1);
          // Final step writes the upper half of the product straight from the adder
          if (cnt == CntW'(N - 1)) begin
            Wdata    <= acc_next[2*N-1:N];
            w_enable <= 1'b1;
            state    <= WB;
          end
        end
        WB: begin
          instr_ready <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          instr_ready <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_exec.sv
// Directed self-checking bench for instr_exec with hand-computed expectations.
module tb_instr_exec;

  localparam int unsigned M  = 32;
  localparam int unsigned N  = 8;
  localparam int unsigned AW = 5;
  localparam int unsigned IW = 4 + 2 * AW + N;

  logic          clk = 1'b0;
  logic          reset;
  logic          instr_valid;
  logic [IW-1:0] instr;
  logic          instr_ready;
  logic [AW-1:0] Rd;
  logic [AW-1:0] Rs;
  logic [N-1:0]  Rd_data;
  logic [N-1:0]  Rs_data;
  logic [N-1:0]  Wdata;
  logic          w_enable;
  logic          branch_taken;
  logic [N-1:0]  branch_offset;

  int checks   = 0;
  int failures = 0;

  logic [15:0] we_mask;
  logic [15:0] bt_mask;
  int          rdy_k;
  logic        ovl;
  logic [N-1:0] first_wdata;
  logic        rdy3;
  logic        rdy4;
  logic        any_strobe;

  instr_exec #(.M(M), .N(N)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .Rd(Rd), .Rs(Rs), .Rd_data(Rd_data), .Rs_data(Rs_data),
    .Wdata(Wdata), .w_enable(w_enable), .branch_taken(branch_taken),
    .branch_offset(branch_offset)
  );

  always #5 clk = ~clk;

  function automatic logic [IW-1:0] mk(input logic [3:0] op, input logic [AW-1:0] rd,
                                       input logic [AW-1:0] rs, input logic [N-1:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one instruction and watch strobes for 15 cycles; k=1 is the cycle after acceptance
  task automatic run(input logic [IW-1:0] ins, input logic [N-1:0] rdd, input logic [N-1:0] rsd);
    Rd_data = rdd;
    Rs_data = rsd;
    instr = ins;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    instr = '1;
    we_mask = '0;
    bt_mask = '0;
    rdy_k = 0;
    ovl = 1'b0;
    for (int k = 1; k < 16; k++) begin
      we_mask[k] = w_enable;
      bt_mask[k] = branch_taken;
      if (w_enable && branch_taken) ovl = 1'b1;
      if (rdy_k == 0 && instr_ready) rdy_k = k;
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1;
    instr_valid = 1'b0;
    instr = '0;
    Rd_data = '0;
    Rs_data = '0;
    @(negedge clk);
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_rd", 32'(Rd), 32'd0);
    chk("rst_rs", 32'(Rs), 32'd0);
    chk("rst_wdata", 32'(Wdata), 32'd0);
    chk("rst_we", 32'(w_enable), 32'd0);
    chk("rst_bt", 32'(branch_taken), 32'd0);
    chk("rst_boff", 32'(branch_offset), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // ADDI rd=3 rs=0 imm=5, Rs_data=0
    run(mk(4'd2, 5'd3, 5'd0, 8'd5), 8'd0, 8'd0);
    chk("addi_we_mask", 32'(we_mask), 32'h0004);
    chk("addi_wdata", 32'(Wdata), 32'd5);
    chk("addi_rd", 32'(Rd), 32'd3);
    chk("addi_ready_k", 32'(rdy_k), 32'd3);
    chk("addi_bt_mask", 32'(bt_mask), 32'h0000);

    // ADD 200+100 wraps to 44
    run(mk(4'd1, 5'd1, 5'd2, 8'd0), 8'd200, 8'd100);
    chk("add_we_mask", 32'(we_mask), 32'h0004);
    chk("add_wdata", 32'(Wdata), 32'd44);
    chk("add_rs", 32'(Rs), 32'd2);

    // SUB 100-200 borrows to 156
    run(mk(4'd3, 5'd1, 5'd2, 8'd0), 8'd100, 8'd200);
    chk("sub_we_mask", 32'(we_mask), 32'h0004);
    chk("sub_wdata", 32'(Wdata), 32'd156);

    // MULI 0xFF*0xFF = 0xFE01, upper byte written at T+10
    run(mk(4'd4, 5'd2, 5'd4, 8'hFF), 8'd0, 8'hFF);
    chk("muli_we_mask", 32'(we_mask), 32'h0400);
    chk("muli_wdata", 32'(Wdata), 32'hFE);
    chk("muli_ready_k", 32'(rdy_k), 32'd11);
    chk("muli_rs", 32'(Rs), 32'd4);

    // MULI 13*20 = 260 -> upper byte 1
    run(mk(4'd4, 5'd2, 5'd4, 8'd20), 8'd0, 8'd13);
    chk("muli2_wdata", 32'(Wdata), 32'd1);

    // BEQ taken
    run(mk(4'd5, 5'd1, 5'd2, 8'hF0), 8'd7, 8'd7);
    chk("beq_bt_mask", 32'(bt_mask), 32'h0004);
    chk("beq_boff", 32'(branch_offset), 32'hF0);
    chk("beq_we_mask", 32'(we_mask), 32'h0000);
    chk("beq_ready_k", 32'(rdy_k), 32'd3);
    chk("beq_wdata_held", 32'(Wdata), 32'd1);

    // BEQ not taken: no pulse, offset holds
    run(mk(4'd5, 5'd1, 5'd2, 8'h11), 8'd7, 8'd8);
    chk("bne_bt_mask", 32'(bt_mask), 32'h0000);
    chk("bne_boff_held", 32'(branch_offset), 32'hF0);
    chk("bne_we_mask", 32'(we_mask), 32'h0000);

    // NOP and undefined opcode return to idle at T+2
    run(mk(4'd0, 5'd1, 5'd2, 8'd3), 8'd1, 8'd2);
    chk("nop_strobes", 32'(we_mask | bt_mask), 32'h0000);
    chk("nop_ready_k", 32'(rdy_k), 32'd2);
    run(mk(4'hF, 5'd1, 5'd2, 8'd3), 8'd1, 8'd1);
    chk("opf_strobes", 32'(we_mask | bt_mask), 32'h0000);
    chk("opf_ready_k", 32'(rdy_k), 32'd2);
    chk("opf_wdata_held", 32'(Wdata), 32'd1);

    // Reset during the 4th MUL cycle abandons the multiply
    Rs_data = 8'hFF;
    instr = mk(4'd4, 5'd6, 5'd4, 8'hFF);
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mrst_we", 32'(w_enable), 32'd0);
    chk("mrst_ready", 32'(instr_ready), 32'd1);
    chk("mrst_rd", 32'(Rd), 32'd0);
    chk("mrst_wdata", 32'(Wdata), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    any_strobe = 1'b0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (w_enable || branch_taken || !instr_ready) any_strobe = 1'b1;
    end
    chk("mrst_after_quiet", 32'(any_strobe), 32'd0);

    // Back-to-back ADDIs with instr_valid held high; rd=0 still writes
    Rs_data = 8'd0;
    instr = mk(4'd2, 5'd0, 5'd0, 8'd5);
    instr_valid = 1'b1;
    @(negedge clk);
    instr = mk(4'd2, 5'd7, 5'd0, 8'd9);
    we_mask = '0;
    first_wdata = '0;
    rdy3 = 1'b0;
    rdy4 = 1'b0;
    ovl = 1'b0;
    for (int k = 1; k < 12; k++) begin
      we_mask[k] = w_enable;
      if (w_enable && branch_taken) ovl = 1'b1;
      if (k == 2) first_wdata = Wdata;
      if (k == 3) rdy3 = instr_ready;
      if (k == 4) begin
        rdy4 = instr_ready;
        instr_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("b2b_we_mask", 32'(we_mask), 32'h0024);
    chk("b2b_first_wdata", 32'(first_wdata), 32'd5);
    chk("b2b_second_wdata", 32'(Wdata), 32'd9);
    chk("b2b_ready_t3", 32'(rdy3), 32'd1);
    chk("b2b_ready_t4", 32'(rdy4), 32'd0);
    chk("b2b_rd", 32'(Rd), 32'd7);
    chk("b2b_no_overlap", 32'(ovl), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
